// File: rtl/mult_div_unit_if.sv
// Request/result bundle between the register-file stage and mult_div_unit.
// MDU_HILO_WRITE_EN adds the MTHI/MTLO write port (hilo_we, hilo_wdata).
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MDU_HILO_WRITE_EN
    logic [1:0]       hilo_we;
    logic [WIDTH-1:0] hilo_wdata;
`endif

    modport master (
`ifdef MDU_HILO_WRITE_EN
        output hilo_we, hilo_wdata,
`endif
        output start, op, src_a, src_b,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
`ifdef MDU_HILO_WRITE_EN
        input  hilo_we, hilo_wdata,
`endif
        input  start, op, src_a, src_b,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit producing HI/LO in 34 cycles.
// Optional MDU_HILO_WRITE_EN adds MTHI/MTLO writes while idle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

    state_t             state;
    logic               is_div;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;
    logic               neg_q;
    logic               neg_r;
    logic               b_zero;
    logic               busy_q;
    logic               done_q;
    logic               dbz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    logic               sgn_a;
    logic               sgn_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    // Magnitudes and signs of the incoming operands (signed ops only)
    always_comb begin
        sgn_a = bus.op[0] & bus.src_a[WIDTH-1];
        sgn_b = bus.op[0] & bus.src_b[WIDTH-1];
        abs_a = sgn_a ? -bus.src_a : bus.src_a;
        abs_b = sgn_b ? -bus.src_b : bus.src_b;
    end

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_top;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;

    // One shift-add / restoring-divide step, plus the sign fix-up
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        div_top  = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_top - {1'b0, opnd};
        div_next = div_diff[WIDTH]
                 ? {acc[2*WIDTH-2:0], 1'b0}
                 : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod     = neg_q ? -acc : acc;
        quo      = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = neg_r ? -acc[2*WIDTH-1:WIDTH]
                         : acc[2*WIDTH-1:WIDTH];
    end

    // Control FSM with registered handshake and HI/LO outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            is_div <= 1'b0;
            a_raw  <= '0;
            opnd   <= '0;
            acc    <= '0;
            count  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
`ifdef MDU_HILO_WRITE_EN
                    if (bus.hilo_we[1]) hi_q <= bus.hilo_wdata;
                    if (bus.hilo_we[0]) lo_q <= bus.hilo_wdata;
`endif
                    if (bus.start) begin
                        is_div <= bus.op[1];
                        a_raw  <= bus.src_a;
                        b_zero <= (bus.src_b == '0);
                        count  <= '0;
                        busy_q <= 1'b1;
                        dbz_q  <= 1'b0;
                        neg_q  <= sgn_a ^ sgn_b;
                        if (bus.op[1]) begin
                            state <= DIV;
                            opnd  <= abs_b;
                            acc   <= {{WIDTH{1'b0}}, abs_a};
                            neg_r <= sgn_a;
                        end else begin
                            state <= MUL;
                            opnd  <= abs_a;
                            acc   <= {{WIDTH{1'b0}}, abs_b};
                            neg_r <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    acc   <= mul_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                DIV: begin
                    acc   <= div_next;
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    if (!is_div) begin
                        hi_q <= prod[2*WIDTH-1:WIDTH];
                        lo_q <= prod[WIDTH-1:0];
                    end else if (b_zero) begin
                        hi_q  <= a_raw;
                        lo_q  <= '1;
                        dbz_q <= 1'b1;
                    end else begin
                        hi_q <= rem;
                        lo_q <= quo;
                    end
                    done_q <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: cycle model plus literal results.
// Define MDU_HILO_WRITE_EN to also exercise the MTHI/MTLO port.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference result: {div_by_zero, hi, lo} from plain arithmetic
    function automatic logic [64:0] ref_res(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        if (op == 2'b00) begin
            p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
        end
        if (op == 2'b01) begin
            sa = $signed(a);
            sb = $signed(b);
            p  = sa * sb;
            return {1'b0, p};
        end
        if (b == 32'h0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == 2'b10) begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end else begin
            sa = $signed(a);
            sb = $signed(b);
        end
        q = sa / sb;
        r = sa % sb;
        return {1'b0, r[31:0], q[31:0]};
    endfunction

    // Cycle-level model: accepted start -> result after 33 edges,
    // busy released after 34; everything cleared by reset.
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_dbz  = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    int          m_cnt  = 0;
    logic [64:0] m_res  = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_dbz  = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            m_cnt  = 0;
        end else if (!m_busy) begin
`ifdef MDU_HILO_WRITE_EN
            if (bus.hilo_we[1]) m_hi = bus.hilo_wdata;
            if (bus.hilo_we[0]) m_lo = bus.hilo_wdata;
`endif
            if (bus.start) begin
                m_res  = ref_res(bus.op, bus.src_a, bus.src_b);
                m_busy = 1'b1;
                m_dbz  = 1'b0;
                m_cnt  = 0;
            end
        end else begin
            m_cnt++;
            if (m_cnt == 33) begin
                m_dbz  = m_res[64];
                m_hi   = m_res[63:32];
                m_lo   = m_res[31:0];
                m_done = 1'b1;
            end
            if (m_cnt == 34) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end
        end
    end

    // Compare every output against the model each cycle
    always @(negedge clk) begin
        chk("cyc_busy", 64'(bus.busy), 64'(m_busy));
        chk("cyc_done", 64'(bus.done), 64'(m_done));
        chk("cyc_dbz", 64'(bus.div_by_zero), 64'(m_dbz));
        chk("cyc_hi", 64'(bus.hi), 64'(m_hi));
        chk("cyc_lo", 64'(bus.lo), 64'(m_lo));
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 100);
    endtask

    task automatic run_op(input string nm, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic ed);
        int n;
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        bus.src_a = ~a;
        bus.src_b = $urandom;
        wait_done(n);
        chk({nm, "_lat"}, 64'(n), 64'd34);
        chk({nm, "_hilo"}, {bus.hi, bus.lo}, {eh, el});
        chk({nm, "_dbz"}, 64'(bus.div_by_zero), 64'(ed));
        @(posedge clk);
        #2;
    endtask

    initial begin
        int n;
        int dones;
        int gaps;
        logic seen;
        logic [64:0] pin;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.src_a = '0;
        bus.src_b = '0;
`ifdef MDU_HILO_WRITE_EN
        bus.hilo_we    = 2'b00;
        bus.hilo_wdata = '0;
`endif
        repeat (3) @(posedge clk);
        #2;
        chk("reset_out", {bus.hi, bus.lo}, 64'd0);
        chk("reset_ctl", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
        reset = 1'b0;

        pin = ref_res(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("model_divovf", pin[63:0], {32'h0, 32'h8000_0000});
        pin = ref_res(2'b10, 32'd100, 32'd0);
        chk("model_dbz", 64'(pin), {1'b1, 32'd100, 32'hFFFF_FFFF});

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_m7x3", 2'b01, 32'hFFFF_FFF9, 32'd3,
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu_zero", 2'b10, 32'd100, 32'd0,
               32'd100, 32'hFFFF_FFFF, 1'b1);
        run_op("divu_100d7", 2'b10, 32'd100, 32'd7,
               32'd2, 32'd14, 1'b0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0, 32'h8000_0000, 1'b0);
        run_op("mult_minsq", 2'b01, 32'h8000_0000, 32'h8000_0000,
               32'h4000_0000, 32'h0, 1'b0);
        run_op("div_7dm2", 2'b11, 32'd7, 32'hFFFF_FFFE,
               32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("div_m7dm2", 2'b11, 32'hFFFF_FFF9, 32'hFFFF_FFFE,
               32'hFFFF_FFFF, 32'd3, 1'b0);
        run_op("multu_shift", 2'b00, 32'h1234_5678, 32'h10,
               32'h1, 32'h2345_6780, 1'b0);
        run_op("div_m5d0", 2'b11, 32'hFFFF_FFFB, 32'd0,
               32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);

        // start pulsed mid-operation must be ignored
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.src_a = 32'd3;
        bus.src_b = 32'd5;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        bus.start = 1'b1;
        bus.src_a = 32'd100;
        bus.src_b = 32'd100;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        dones = 0;
        gaps  = 0;
        seen  = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!seen && !bus.busy) gaps++;
            if (bus.done) begin
                dones++;
                seen = 1'b1;
                chk("ign_hilo", {bus.hi, bus.lo}, {32'd0, 32'd15});
            end
        end
        chk("ign_dones", 64'(dones), 64'd1);
        chk("ign_busy_gap", 64'(gaps), 64'd0);
        @(posedge clk);
        #2;

        // asynchronous reset at E15 of a DIV aborts with no done
        bus.start = 1'b1;
        bus.op    = 2'b11;
        bus.src_a = 32'd1000;
        bus.src_b = 32'd3;
        @(posedge clk);
        #2;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst_ctl", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("rst_no_done", 64'(dones), 64'd0);
        @(posedge clk);
        #2;
        run_op("divu_9d4", 2'b10, 32'd9, 32'd4, 32'd1, 32'd2, 1'b0);

        // start held through DONE is taken only at the first IDLE edge
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.src_a = 32'd6;
        bus.src_b = 32'd7;
        @(posedge clk);
        #2;
        wait_done(n);
        chk("hold_lat", 64'(n), 64'd34);
        chk("hold_hilo", {bus.hi, bus.lo}, 64'd42);
        @(posedge clk);
        #2;
        chk("hold_idle_gap", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #2;
        chk("hold_reaccept", 64'(bus.busy), 64'd1);
        bus.start = 1'b0;
        wait_done(n);
        chk("hold2_lat", 64'(n), 64'd34);
        @(posedge clk);
        #2;

`ifdef MDU_HILO_WRITE_EN
        bus.hilo_we    = 2'b11;
        bus.hilo_wdata = 32'h1234_5678;
        @(posedge clk);
        #2;
        bus.hilo_we = 2'b00;
        chk("mthilo_idle", {bus.hi, bus.lo}, {2{32'h1234_5678}});
        bus.hilo_we    = 2'b10;
        bus.hilo_wdata = 32'hCAFE_0001;
        @(posedge clk);
        #2;
        bus.hilo_we = 2'b00;
        chk("mthi_only", {bus.hi, bus.lo}, {32'hCAFE_0001, 32'h1234_5678});
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.src_a = 32'd2;
        bus.src_b = 32'd3;
        @(posedge clk);
        #2;
        bus.start      = 1'b0;
        bus.hilo_we    = 2'b11;
        bus.hilo_wdata = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #2;
        bus.hilo_we = 2'b00;
        chk("mthilo_busy", {bus.hi, bus.lo}, {32'hCAFE_0001, 32'h1234_5678});
        wait_done(n);
        chk("mthilo_res", {bus.hi, bus.lo}, 64'd6);
        @(posedge clk);
        #2;
`endif

        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
